// File: rtl/function_lookup_table_if.sv
// Data bundle for function_lookup_table: evaluation inputs, LUT write port and
// the three registered results. The master drives inputs; the slave is the evaluator.
interface function_lookup_table_if #(
    parameter int W_X = 4,
    parameter int W_Y = 8
);
    logic signed [W_X-1:0] xf;
    logic signed [W_X-1:0] xq;
    logic signed [W_X-1:0] xiq;
    logic signed [W_Y-1:0] yiq;
    logic                  lut_we;
    logic signed [W_Y-1:0] yf;
    logic signed [W_Y-1:0] yq_fun;
    logic signed [W_Y-1:0] yq_lut;

    modport master (
        output xf, xq, xiq, yiq, lut_we,
        input  yf, yq_fun, yq_lut
    );

    modport slave (
        input  xf, xq, xiq, yiq, lut_we,
        output yf, yq_fun, yq_lut
    );
endinterface

// File: rtl/function_lookup_table.sv
// Evaluates f(x) = x*x + x, saturated to W_Y bits, on two arithmetic channels
// and through a run-time writable 2^W_X-entry lookup table.
module function_lookup_table #(
    parameter int W_X = 4,
    parameter int W_Y = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    function_lookup_table_if.slave  bus
);
    localparam int DEPTH = 1 << W_X;
    localparam int W_F   = 2 * W_X + 1;
    localparam int W_C   = (W_F > W_Y) ? W_F : W_Y;

    // Full-precision evaluation followed by clamping into the signed W_Y range.
    function automatic logic signed [W_Y-1:0] sat_f(input logic signed [W_X-1:0] x);
        logic signed [W_C-1:0] xe;
        logic signed [W_C-1:0] full;
        logic signed [W_C-1:0] hi;
        logic signed [W_C-1:0] lo;
        xe            = {{(W_C-W_X){x[W_X-1]}}, x};
        full          = xe * xe + xe;
        hi            = '0;
        hi[W_Y-2:0]   = '1;
        lo            = '1;
        lo[W_Y-2:0]   = '0;
        if (full > hi) begin
            sat_f = hi[W_Y-1:0];
        end else if (full < lo) begin
            sat_f = lo[W_Y-1:0];
        end else begin
            sat_f = full[W_Y-1:0];
        end
    endfunction

    logic signed [W_Y-1:0] r_lut [0:DEPTH-1];
    logic signed [W_Y-1:0] r_yf;
    logic signed [W_Y-1:0] r_yq_fun;
    logic signed [W_Y-1:0] r_yq_lut;

    logic        [W_X-1:0] w_rd_idx;
    logic        [W_X-1:0] w_wr_idx;
    logic signed [W_Y-1:0] w_yf_fun;
    logic signed [W_Y-1:0] w_yq_fun;

    // Table indices use the raw two's complement bit pattern, so -8 selects entry 8.
    assign w_rd_idx = bus.xq;
    assign w_wr_idx = bus.xiq;
    assign w_yf_fun = sat_f(bus.xf);
    assign w_yq_fun = sat_f(bus.xq);

    // Output registers and table; reset reloads the table and overrides any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_yf     <= '0;
            r_yq_fun <= '0;
            r_yq_lut <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_lut[i[W_X-1:0]] <= sat_f(i[W_X-1:0]);
            end
        end else begin
            r_yf     <= w_yf_fun;
            r_yq_fun <= w_yq_fun;
            r_yq_lut <= r_lut[w_rd_idx];
            if (bus.lut_we) begin
                r_lut[w_wr_idx] <= bus.yiq;
            end
        end
    end

    assign bus.yf     = r_yf;
    assign bus.yq_fun = r_yq_fun;
    assign bus.yq_lut = r_yq_lut;
endmodule

// File: tb/tb_function_lookup_table.sv
// Self-checking bench: two evaluators (W_Y=8 and the saturating W_Y=6) driven in
// lockstep and compared against an integer reference model of f and the table.
module tb_function_lookup_table;
    logic clk = 1'b0;
    logic rst;

    function_lookup_table_if #(.W_X(4), .W_Y(8)) b8 ();
    function_lookup_table_if #(.W_X(4), .W_Y(6)) b6 ();

    function_lookup_table #(.W_X(4), .W_Y(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    function_lookup_table #(.W_X(4), .W_Y(6)) dut6 (.clk(clk), .rst(rst), .bus(b6.slave));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int lut8 [16];
    int lut6 [16];
    int cur_xf, cur_xq, cur_xiq, cur_yiq, cur_we, cur_rst;

    function automatic int fref(input int x, input int wy);
        int v;
        int mx;
        v  = x * x + x;
        mx = (1 << (wy - 1)) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int sx(input int v, input int w);
        int m;
        m = v & ((1 << w) - 1);
        return (m >= (1 << (w - 1))) ? m - (1 << w) : m;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            lut8[i] = fref(sx(i, 4), 8);
            lut6[i] = fref(sx(i, 4), 6);
        end
    endtask

    task automatic drive(input int xf, input int xq, input int xiq, input int yiq,
                         input int we, input int r);
        logic [3:0] vxf, vxq, vxiq;
        logic [7:0] vyiq;
        cur_xf = sx(xf, 4); cur_xq = sx(xq, 4); cur_xiq = xiq & 15;
        cur_yiq = sx(yiq, 8); cur_we = we; cur_rst = r;
        vxf = xf[3:0]; vxq = xq[3:0]; vxiq = xiq[3:0]; vyiq = yiq[7:0];
        b8.xf = vxf; b8.xq = vxq; b8.xiq = vxiq; b8.yiq = vyiq; b8.lut_we = we[0];
        b6.xf = vxf; b6.xq = vxq; b6.xiq = vxiq; b6.yiq = vyiq[5:0]; b6.lut_we = we[0];
        rst = r[0];
    endtask

    // One clock: predict outputs from pre-edge model, update model, then compare.
    task automatic cycle();
        int e8f, e8q, e8l, e6f, e6q, e6l;
        if (cur_rst != 0) begin
            e8f = 0; e8q = 0; e8l = 0; e6f = 0; e6q = 0; e6l = 0;
            model_reset();
        end else begin
            e8f = fref(cur_xf, 8); e8q = fref(cur_xq, 8); e8l = lut8[cur_xq & 15];
            e6f = fref(cur_xf, 6); e6q = fref(cur_xq, 6); e6l = lut6[cur_xq & 15];
            if (cur_we != 0) begin
                lut8[cur_xiq] = cur_yiq;
                lut6[cur_xiq] = sx(cur_yiq, 6);
            end
        end
        @(posedge clk);
        #1;
        chk("yf8",     int'(b8.yf),     e8f);
        chk("yq_fun8", int'(b8.yq_fun), e8q);
        chk("yq_lut8", int'(b8.yq_lut), e8l);
        chk("yf6",     int'(b6.yf),     e6f);
        chk("yq_fun6", int'(b6.yq_fun), e6q);
        chk("yq_lut6", int'(b6.yq_lut), e6l);
    endtask

    initial begin
        model_reset();
        // Reset with x=3 held: outputs stay 0
        drive(3, 3, 0, 0, 0, 1);
        cycle();
        cycle();
        chk("rst_yq_lut", int'(b8.yq_lut), 0);
        // First post-reset edge
        drive(3, 3, 0, 0, 0, 0);
        cycle();
        chk("first_yf", int'(b8.yf), 12);
        chk("first_yq_fun", int'(b8.yq_fun), 12);
        chk("first_yq_lut", int'(b8.yq_lut), 12);

        // Full sweep -8..7
        for (int x = -8; x <= 7; x++) begin
            drive(x, x, 0, 0, 0, 0);
            cycle();
            if (x == -8) chk("sweep_m8", int'(b8.yq_lut), 56);
            if (x == -1) chk("sweep_m1", int'(b8.yq_fun), 0);
            if (x == 0)  chk("sweep_0",  int'(b8.yf), 0);
            if (x == 7)  chk("sweep_7",  int'(b8.yq_lut), 56);
            if (x == 7)  chk("sat6_7",   int'(b6.yq_lut), 31);
            if (x == 4)  chk("sat6_4",   int'(b6.yq_fun), 20);
        end

        // LUT override at address 3
        drive(0, 0, 3, 99, 1, 0);
        cycle();
        drive(3, 3, 0, 0, 0, 0);
        cycle();
        chk("ovr_lut", int'(b8.yq_lut), 99);
        chk("ovr_fun", int'(b8.yq_fun), 12);
        drive(2, 2, 0, 0, 0, 0);
        cycle();
        chk("ovr_other", int'(b8.yq_lut), 6);

        // Same-cycle read and write at address 5
        drive(5, 5, 5, -7, 1, 0);
        cycle();
        chk("rw_old", int'(b8.yq_lut), 30);
        drive(5, 5, 0, 0, 0, 0);
        cycle();
        chk("rw_new", int'(b8.yq_lut), -7);

        // Reset mid-operation with a write pending
        drive(3, 3, 3, 50, 1, 1);
        cycle();
        chk("mid_rst", int'(b8.yq_lut), 0);
        drive(3, 3, 0, 0, 0, 0);
        cycle();
        chk("restored", int'(b8.yq_lut), 12);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            drive(int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(15)), int'($urandom_range(255)),
                  ($urandom_range(3) == 0) ? 1 : 0,
                  ($urandom_range(31) == 0) ? 1 : 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
